// File: rtl/gtwizard_0_reset_pkg.sv
// Shared definitions for the GT reset path: FSM states and cycle-count helpers.
package gtwizard_0_reset_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_LOCK   = 3'd1,
    ST_LOCK_FILTER = 3'd2,
    ST_READY       = 3'd3,
    ST_RESET_HOLD  = 3'd4,
    ST_FAILED      = 3'd5
  } qpll_state_t;

  // Ceiling log2, never less than 1 so it can size a vector directly.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < value) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

  // Convert a duration in ns to whole STABLE_CLOCK cycles.
  function automatic int ns_to_cycles(input int ns, input int period_ns);
    return ns / period_ns;
  endfunction

endpackage

// File: rtl/gtwizard_0_sync_block.sv
// Two-flop synchronizer for single-bit async status signals.
module gtwizard_0_sync_block #(
  parameter bit USE_ASYNC_REG = 1'b1
) (
  input  logic i_clk,
  input  logic i_data,
  output logic o_data
);

  if (USE_ASYNC_REG) begin : g_async
    (* ASYNC_REG = "TRUE" *) logic r_meta;
    (* ASYNC_REG = "TRUE" *) logic r_sync;
    // Metastability settling chain, kept together by placement attributes.
    always_ff @(posedge i_clk) begin
      r_meta <= i_data;
      r_sync <= r_meta;
    end
    assign o_data = r_sync;
  end else begin : g_plain
    logic r_meta;
    logic r_sync;
    // Same chain without placement attributes.
    always_ff @(posedge i_clk) begin
      r_meta <= i_data;
      r_sync <= r_meta;
    end
    assign o_data = r_sync;
  end

endmodule

// File: rtl/gtwizard_0_qpll_lock_monitor.sv
// Forwards the common QPLL reset, debounces QPLLLOCK, retries on timeout
// and recovers automatically from loss of lock.
module gtwizard_0_qpll_lock_monitor
  import gtwizard_0_reset_pkg::*;
#(
  parameter int STABLE_CLOCK_PERIOD = 8,
  parameter int LOCK_TIMEOUT_NS     = 100000,
  parameter int LOCK_STABLE_CYCLES  = 64,
  parameter int MAX_RETRIES         = 3,
  parameter int RESET_PULSE_CYCLES  = 4
) (
  input  logic                                STABLE_CLOCK,
  input  logic                                SOFT_RESET,
  input  logic                                COMMON_RESET_IN,
  input  logic                                QPLLLOCK,
  output logic                                QPLL_RESET_OUT,
  output logic                                QPLL_READY,
  output logic                                LOCK_LOST,
  output logic [clog2(MAX_RETRIES+1)-1:0]     RETRY_COUNT,
  output logic                                QPLL_FAIL
);

  localparam int TIMEOUT_CYCLES = ns_to_cycles(LOCK_TIMEOUT_NS, STABLE_CLOCK_PERIOD);
  localparam int TMO_W  = clog2(TIMEOUT_CYCLES);
  localparam int STAB_W = clog2(LOCK_STABLE_CYCLES + 1);
  localparam int HOLD_W = clog2(RESET_PULSE_CYCLES);
  localparam int RTY_W  = clog2(MAX_RETRIES + 1);

  qpll_state_t       r_state, w_state_nxt;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [STAB_W-1:0] r_stab_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [RTY_W-1:0]  r_retry;
  logic              r_reset_out;
  logic              r_lock_lost;
  logic              w_lock_s;
  logic              w_tmo_done, w_stab_done, w_hold_done, w_rty_max;
  logic              w_retry_inc, w_retry_clr, w_lost_set;

  gtwizard_0_sync_block #(.USE_ASYNC_REG(1'b1)) u_lock_sync (
    .i_clk  (STABLE_CLOCK),
    .i_data (QPLLLOCK),
    .o_data (w_lock_s)
  );

  assign w_tmo_done  = (r_tmo_cnt  == TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_stab_done = (r_stab_cnt == STAB_W'(LOCK_STABLE_CYCLES - 1));
  assign w_hold_done = (r_hold_cnt == HOLD_W'(RESET_PULSE_CYCLES - 1));
  assign w_rty_max   = (r_retry    == RTY_W'(MAX_RETRIES));

  // Next state: a common reset restarts acquisition from any state; a timeout
  // retries until the budget is spent; stable completion beats a timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_retry_inc = 1'b0;
    w_retry_clr = 1'b0;
    w_lost_set  = 1'b0;
    if (COMMON_RESET_IN) begin
      w_state_nxt = ST_WAIT_LOCK;
      w_retry_clr = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_WAIT_LOCK: begin
          if (w_lock_s) w_state_nxt = ST_LOCK_FILTER;
          else if (w_tmo_done) begin
            if (w_rty_max) w_state_nxt = ST_FAILED;
            else begin
              w_state_nxt = ST_RESET_HOLD;
              w_retry_inc = 1'b1;
            end
          end
        end
        ST_LOCK_FILTER: begin
          if (w_lock_s && w_stab_done) w_state_nxt = ST_READY;
          else if (w_tmo_done) begin
            if (w_rty_max) w_state_nxt = ST_FAILED;
            else begin
              w_state_nxt = ST_RESET_HOLD;
              w_retry_inc = 1'b1;
            end
          end else if (!w_lock_s) w_state_nxt = ST_WAIT_LOCK;
        end
        ST_READY: begin
          if (!w_lock_s) begin
            w_state_nxt = ST_RESET_HOLD;
            w_retry_clr = 1'b1;
            w_lost_set  = 1'b1;
          end
        end
        ST_RESET_HOLD: if (w_hold_done) w_state_nxt = ST_WAIT_LOCK;
        ST_FAILED: ;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, counters and registered outputs. The timeout counter runs across
  // WAIT_LOCK/LOCK_FILTER so lock glitches cannot extend the timeout window.
  always_ff @(posedge STABLE_CLOCK) begin
    if (SOFT_RESET) begin
      r_state     <= ST_IDLE;
      r_tmo_cnt   <= '0;
      r_stab_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_retry     <= '0;
      r_reset_out <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_reset_out <= COMMON_RESET_IN | (r_state == ST_RESET_HOLD);
      if (w_lost_set) r_lock_lost <= 1'b1;

      if (w_retry_clr)      r_retry <= '0;
      else if (w_retry_inc) r_retry <= r_retry + RTY_W'(1);

      if (COMMON_RESET_IN) r_tmo_cnt <= '0;
      else if (r_state == ST_WAIT_LOCK || r_state == ST_LOCK_FILTER) begin
        if (!w_tmo_done) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end else r_tmo_cnt <= '0;

      if (COMMON_RESET_IN || r_state != ST_LOCK_FILTER) r_stab_cnt <= '0;
      else if (w_lock_s && !w_stab_done) r_stab_cnt <= r_stab_cnt + STAB_W'(1);

      if (r_state == ST_RESET_HOLD && !w_hold_done) r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      else r_hold_cnt <= '0;
    end
  end

  assign QPLL_RESET_OUT = r_reset_out;
  assign QPLL_READY     = (r_state == ST_READY);
  assign QPLL_FAIL      = (r_state == ST_FAILED);
  assign LOCK_LOST      = r_lock_lost;
  assign RETRY_COUNT    = r_retry;

endmodule

// File: tb/tb_gtwizard_0_qpll_lock_monitor.sv
// Directed bench for the QPLL lock monitor (100-cycle timeout, 8-cycle filter,
// 2 retries, 4-cycle reset pulse).
module tb_gtwizard_0_qpll_lock_monitor;

  logic       clk = 1'b0;
  logic       soft_rst, common_rst, qplllock;
  logic       reset_out, ready, lost, fail;
  logic [1:0] retry;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  gtwizard_0_qpll_lock_monitor #(
    .STABLE_CLOCK_PERIOD (8),
    .LOCK_TIMEOUT_NS     (800),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2),
    .RESET_PULSE_CYCLES  (4)
  ) dut (
    .STABLE_CLOCK    (clk),
    .SOFT_RESET      (soft_rst),
    .COMMON_RESET_IN (common_rst),
    .QPLLLOCK        (qplllock),
    .QPLL_RESET_OUT  (reset_out),
    .QPLL_READY      (ready),
    .LOCK_LOST       (lost),
    .RETRY_COUNT     (retry),
    .QPLL_FAIL       (fail)
  );

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_soft_reset();
    soft_rst = 1'b1; common_rst = 1'b0; qplllock = 1'b0;
    step(3);
    soft_rst = 1'b0;
  endtask

  // Common reset sampled at edge E0; returns just after E1.
  task automatic start_acq();
    common_rst = 1'b1; step(1);
    common_rst = 1'b0; step(1);
  endtask

  task automatic test_reset();
    do_soft_reset();
    n_cmp++; if ({reset_out, ready, lost, fail, retry} !== 6'b0) begin n_bad++; $display("FAIL reset_outputs: got %b want 000000", {reset_out, ready, lost, fail, retry}); end
    step(5);
    n_cmp++; if ({reset_out, ready, fail} !== 3'b0) begin n_bad++; $display("FAIL idle_hold: got %b want 000", {reset_out, ready, fail}); end
  endtask

  task automatic test_clean_lock();
    common_rst = 1'b1; step(1);
    n_cmp++; if (reset_out !== 1'b1) begin n_bad++; $display("FAIL clean_rst_pulse: got %b want 1", reset_out); end
    common_rst = 1'b0; step(1);
    n_cmp++; if (reset_out !== 1'b0) begin n_bad++; $display("FAIL clean_rst_end: got %b want 0", reset_out); end
    step(18);
    qplllock = 1'b1;
    step(10);
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL clean_ready_early: got %b want 0", ready); end
    step(1);
    n_cmp++; if ({ready, retry, reset_out} !== 4'b1000) begin n_bad++; $display("FAIL clean_ready: got %b want 1000", {ready, retry, reset_out}); end
  endtask

  task automatic test_glitch();
    logic seen;
    do_soft_reset();
    start_acq();
    step(19);
    seen = 1'b0;
    qplllock = 1'b1;
    for (int i = 0; i < 5; i++) begin step(1); seen |= ready; end
    qplllock = 1'b0;
    for (int i = 0; i < 3; i++) begin step(1); seen |= ready; end
    qplllock = 1'b1;
    for (int i = 0; i < 10; i++) begin step(1); seen |= ready; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL glitch_no_ready: got %b want 0", seen); end
    step(1);
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL glitch_ready: got %b want 1", ready); end
    // Late glitch: timeout counter keeps running through the drop, so the
    // timeout at E100 fires before the filter can complete.
    do_soft_reset();
    start_acq();
    step(84);
    qplllock = 1'b1; step(5);
    qplllock = 1'b0; step(3);
    qplllock = 1'b1; step(7);
    n_cmp++; if ({ready, retry} !== 3'b001) begin n_bad++; $display("FAIL glitch_tmo_kept: got %b want 001", {ready, retry}); end
  endtask

  task automatic test_timeout_retries();
    logic bad;
    do_soft_reset();
    start_acq();
    step(98);
    n_cmp++; if ({reset_out, retry} !== 3'b000) begin n_bad++; $display("FAIL tmo_before: got %b want 000", {reset_out, retry}); end
    step(1);
    n_cmp++; if ({reset_out, retry} !== 3'b001) begin n_bad++; $display("FAIL tmo_retry1: got %b want 001", {reset_out, retry}); end
    step(1);
    n_cmp++; if (reset_out !== 1'b1) begin n_bad++; $display("FAIL tmo_pulse1_start: got %b want 1", reset_out); end
    step(3);
    n_cmp++; if (reset_out !== 1'b1) begin n_bad++; $display("FAIL tmo_pulse1_last: got %b want 1", reset_out); end
    step(1);
    n_cmp++; if (reset_out !== 1'b0) begin n_bad++; $display("FAIL tmo_pulse1_end: got %b want 0", reset_out); end
    step(99);
    n_cmp++; if ({reset_out, retry} !== 3'b010) begin n_bad++; $display("FAIL tmo_retry2: got %b want 010", {reset_out, retry}); end
    step(1);
    n_cmp++; if (reset_out !== 1'b1) begin n_bad++; $display("FAIL tmo_pulse2_start: got %b want 1", reset_out); end
    step(4);
    n_cmp++; if (reset_out !== 1'b0) begin n_bad++; $display("FAIL tmo_pulse2_end: got %b want 0", reset_out); end
    step(98);
    n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL tmo_fail_early: got %b want 0", fail); end
    step(1);
    n_cmp++; if ({fail, ready, retry} !== 4'b1010) begin n_bad++; $display("FAIL tmo_failed: got %b want 1010", {fail, ready, retry}); end
    bad = 1'b0;
    for (int i = 0; i < 500; i++) begin step(1); if (fail !== 1'b1 || reset_out !== 1'b0 || ready !== 1'b0) bad = 1'b1; end
    n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL tmo_stay_failed: got %b want 0", bad); end
  endtask

  task automatic test_common_in_failed();
    common_rst = 1'b1; step(1);
    n_cmp++; if ({fail, retry, reset_out} !== 4'b0001) begin n_bad++; $display("FAIL failed_restart: got %b want 0001", {fail, retry, reset_out}); end
    common_rst = 1'b0; qplllock = 1'b1;
    step(10);
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL failed_relock_early: got %b want 0", ready); end
    step(1);
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL failed_relock: got %b want 1", ready); end
  endtask

  task automatic test_loss_of_lock();
    qplllock = 1'b0;
    step(2);
    n_cmp++; if ({ready, lost} !== 2'b10) begin n_bad++; $display("FAIL lol_still_ready: got %b want 10", {ready, lost}); end
    step(1);
    n_cmp++; if ({ready, lost, retry} !== 4'b0100) begin n_bad++; $display("FAIL lol_detect: got %b want 0100", {ready, lost, retry}); end
    qplllock = 1'b1;
    step(1);
    n_cmp++; if (reset_out !== 1'b1) begin n_bad++; $display("FAIL lol_pulse_start: got %b want 1", reset_out); end
    step(3);
    n_cmp++; if (reset_out !== 1'b1) begin n_bad++; $display("FAIL lol_pulse_last: got %b want 1", reset_out); end
    step(1);
    n_cmp++; if (reset_out !== 1'b0) begin n_bad++; $display("FAIL lol_pulse_end: got %b want 0", reset_out); end
    step(7);
    n_cmp++; if ({ready, lost} !== 2'b01) begin n_bad++; $display("FAIL lol_relock_early: got %b want 01", {ready, lost}); end
    step(1);
    n_cmp++; if ({ready, lost, reset_out} !== 3'b110) begin n_bad++; $display("FAIL lol_relock: got %b want 110", {ready, lost, reset_out}); end
  endtask

  task automatic test_soft_reset_mid();
    common_rst = 1'b1; step(1);
    n_cmp++; if ({ready, lost} !== 2'b01) begin n_bad++; $display("FAIL mid_lost_kept: got %b want 01", {ready, lost}); end
    common_rst = 1'b0;
    step(4);
    soft_rst = 1'b1; step(1);
    n_cmp++; if ({reset_out, ready, lost, fail, retry} !== 6'b0) begin n_bad++; $display("FAIL mid_soft_reset: got %b want 000000", {reset_out, ready, lost, fail, retry}); end
    soft_rst = 1'b0;
    step(20);
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL mid_stays_idle: got %b want 0", ready); end
  endtask

  task automatic test_simultaneous();
    do_soft_reset();
    start_acq();
    step(98);
    common_rst = 1'b1; step(1);
    n_cmp++; if ({reset_out, retry} !== 3'b100) begin n_bad++; $display("FAIL sim_tmo_restart: got %b want 100", {reset_out, retry}); end
    common_rst = 1'b0; step(1);
    n_cmp++; if ({reset_out, retry, fail} !== 4'b0000) begin n_bad++; $display("FAIL sim_tmo_no_hold: got %b want 0000", {reset_out, retry, fail}); end
    step(100);
    n_cmp++; if ({reset_out, retry} !== 3'b101) begin n_bad++; $display("FAIL sim_hold_entered: got %b want 101", {reset_out, retry}); end
    common_rst = 1'b1; step(1);
    n_cmp++; if ({reset_out, retry} !== 3'b100) begin n_bad++; $display("FAIL sim_hold_restart: got %b want 100", {reset_out, retry}); end
    common_rst = 1'b0; step(1);
    n_cmp++; if ({reset_out, retry} !== 3'b000) begin n_bad++; $display("FAIL sim_hold_cut: got %b want 000", {reset_out, retry}); end
  endtask

  initial begin
    soft_rst = 1'b1; common_rst = 1'b0; qplllock = 1'b0;
    test_reset();
    test_clean_lock();
    test_glitch();
    test_timeout_retries();
    test_common_in_failed();
    test_loss_of_lock();
    test_soft_reset_mid();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gtwizard_0_qpll_lock_monitor.md
Name: gtwizard_0_qpll_lock_monitor

Overview:
- Receiving end of the QPLL common-reset path. It takes the one-cycle common-reset pulse and forwards it to the QPLL.
- It then watches the asynchronous QPLLLOCK, debounces it, and reports QPLL_READY.
- On lock timeout it re-issues reset, up to a retry budget; on loss of lock after READY it recovers automatically.
- Sits between the common reset generator and the GT TX/RX reset FSMs, all on STABLE_CLOCK.

Parameters:
- STABLE_CLOCK_PERIOD, 8, period of STABLE_CLOCK in ns.
- LOCK_TIMEOUT_NS, 100000, maximum time from reset release to stable lock. Internal: TIMEOUT_CYCLES = LOCK_TIMEOUT_NS / STABLE_CLOCK_PERIOD.
- LOCK_STABLE_CYCLES, 64, consecutive synchronized-lock cycles required before READY.
- MAX_RETRIES, 3, reset re-issues allowed before declaring failure.
- RESET_PULSE_CYCLES, 4, width of a self-generated QPLL reset pulse.

Ports:
- STABLE_CLOCK  in  1  stable free-running clock; the only clock.
- SOFT_RESET  in  1  synchronous, active-high reset.
- COMMON_RESET_IN  in  1  reset pulse from the common reset generator; starts or restarts lock acquisition.
- QPLLLOCK  in  1  asynchronous QPLL lock indicator from the GT.
- QPLL_RESET_OUT  out  1  registered QPLL reset: COMMON_RESET_IN or internal retry pulse.
- QPLL_READY  out  1  QPLL locked and debounced.
- LOCK_LOST  out  1  sticky: lock dropped while READY.
- RETRY_COUNT  out  $clog2(MAX_RETRIES+1)  retries issued in the current acquisition.
- QPLL_FAIL  out  1  retry budget exhausted.

Behaviour:
- Reset and priority
  - Reset is synchronous, active-high, and happens on SOFT_RESET.
  - All outputs are 0 after SOFT_RESET; the FSM goes to IDLE and all counters clear.
  - Priority: SOFT_RESET > COMMON_RESET_IN > FSM transitions.
- Lock synchronizer
  - QPLLLOCK passes through a 2-flop synchronizer to give lock_s; the FSM sees lock_s only.
- QPLL_RESET_OUT
  - Registered: next value = COMMON_RESET_IN | (state==RESET_HOLD).
  - One-cycle latency from COMMON_RESET_IN.
- Restart on COMMON_RESET_IN
  - COMMON_RESET_IN=1 in any state sends the FSM to WAIT_LOCK.
  - This clears the timeout count, stable count, RETRY_COUNT, QPLL_FAIL and QPLL_READY. LOCK_LOST is not cleared.
- IDLE
  - Outputs are idle; the FSM waits for COMMON_RESET_IN.
- WAIT_LOCK
  - tmo_cnt increments each cycle.
  - lock_s=1 → LOCK_FILTER with stab_cnt=0.
  - tmo_cnt==TIMEOUT_CYCLES-1 with RETRY_COUNT<MAX_RETRIES → RESET_HOLD, RETRY_COUNT+1.
  - tmo_cnt==TIMEOUT_CYCLES-1 with RETRY_COUNT==MAX_RETRIES → FAILED.
- RESET_HOLD
  - QPLL_RESET_OUT is held high for exactly RESET_PULSE_CYCLES cycles.
  - Then → WAIT_LOCK with tmo_cnt=0.
- LOCK_FILTER
  - stab_cnt increments while lock_s=1; tmo_cnt keeps counting.
  - lock_s=0 → WAIT_LOCK; tmo_cnt is kept, not cleared.
  - stab_cnt==LOCK_STABLE_CYCLES-1 → READY.
  - Timeout in this state follows the same rule as WAIT_LOCK. If timeout and stable completion occur in the same cycle, READY wins.
- READY
  - QPLL_READY=1.
  - lock_s=0 → QPLL_READY=0 and LOCK_LOST=1 on the next edge, RETRY_COUNT=0, → RESET_HOLD.
- FAILED
  - QPLL_FAIL=1 and QPLL_READY=0.
  - Leaves only on COMMON_RESET_IN or SOFT_RESET.
- Latency
  - With QPLLLOCK stable high from cycle 0 of WAIT_LOCK, QPLL_READY rises at cycle LOCK_STABLE_CYCLES+3.
- Counter widths
  - tmo_cnt is $clog2(TIMEOUT_CYCLES) bits; stab_cnt is $clog2(LOCK_STABLE_CYCLES+1) bits.
  - Neither counter wraps: both saturate at their compare values.
- Other rules
  - A COMMON_RESET_IN pulse during RESET_HOLD restarts the acquisition in WAIT_LOCK, and QPLL_RESET_OUT follows that pulse.
  - QPLL_READY is never high in the same cycle as QPLL_RESET_OUT.

Decomposition:
- Shared package/include gtwizard_0_reset_pkg holds:
  - FSM state encodings: IDLE, WAIT_LOCK, LOCK_FILTER, READY, RESET_HOLD, FAILED;
  - a clog2 helper function;
  - the cycle-count derivation from ns and STABLE_CLOCK_PERIOD, shared with the common reset generator.
- One sub-module: gtwizard_0_sync_block, a 2-flop synchronizer with optional ASYNC_REG attributes. It is reused by the TX/RX reset FSMs.

Test Plan:
All scenarios use overrides LOCK_TIMEOUT_NS=800 (100 cycles), LOCK_STABLE_CYCLES=8, MAX_RETRIES=2, RESET_PULSE_CYCLES=4.
1. Clean lock: 1-cycle COMMON_RESET_IN, then QPLLLOCK=1 from 20 cycles later.
   → QPLL_RESET_OUT high for 1 cycle, 1 cycle after the input pulse; QPLL_READY rises 11 cycles after QPLLLOCK; RETRY_COUNT=0.
2. Glitchy lock: QPLLLOCK pulses high for 5 cycles, low for 3, then stays high.
   → no READY during the glitch; READY 11 cycles after the final rise; tmo_cnt not reset.
3. Timeout and retries: QPLLLOCK stuck at 0.
   → QPLL_RESET_OUT 4-cycle pulses at ~cycle 100 and ~cycle 204; RETRY_COUNT goes 1 then 2; QPLL_FAIL=1 after the third timeout; FSM stays FAILED for 500 cycles.
4. Loss of lock: reach READY, then drop QPLLLOCK.
   → QPLL_READY=0 within 3 cycles; LOCK_LOST=1 sticky; 4-cycle QPLL_RESET_OUT; re-lock gives READY again with LOCK_LOST still 1.
5. Reset mid-operation: SOFT_RESET during LOCK_FILTER, and COMMON_RESET_IN during FAILED.
   → SOFT_RESET: all outputs 0 on the next edge, IDLE.
   → COMMON_RESET_IN: QPLL_FAIL and RETRY_COUNT cleared, acquisition restarts.
6. Simultaneous events: COMMON_RESET_IN in the same cycle as a timeout, and during RESET_HOLD.
   → restart to WAIT_LOCK takes precedence; RETRY_COUNT=0; no retry increment.
